id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage of the vector ASIP; sits directly downstream of the control unit.
- Registers the decoded control word, register-file operands and immediate for the execute stage.
- Detects load-use hazards and inserts bubbles; absorbs branch flushes and execute-side back-pressure.
- Keeps a saturating count of inserted load-use bubbles for performance profiling.

Parameters:
- DATA_W, 128, vector operand width (4 RGBA pixels x 32 bit).
- REG_AW, 4, register address width.
- IMM_W, 16, immediate field width, pre-extension.
- CNT_W, 16, bubble counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- id_valid  in  1  decode slot holds a real instruction.
- id_wmem, id_rmem, id_wreg, id_cond_en, id_jmp_sel, id_vf  in  1 each  control-unit outputs.
- id_jmp_f  in  2  jump flags.
- id_alu_ins  in  3  ALU operation.
- id_extnd_sel  in  2  extend select.
- id_rs1, id_rs2, id_rd  in  REG_AW each  source/destination register addresses.
- id_rs1_used, id_rs2_used  in  1 each  the source is actually read.
- id_data1, id_data2  in  DATA_W each  register-file read data.
- id_imm  in  IMM_W  raw immediate.
- flush  in  1  execute resolved a taken jump; kill the decode-slot instruction.
- ex_stall  in  1  execute cannot accept; hold the stage.
- ex_valid  out  1  registered valid.
- ex_wmem, ex_rmem, ex_wreg, ex_cond_en, ex_jmp_sel, ex_vf, ex_jmp_f, ex_alu_ins, ex_extnd_sel, ex_rs1, ex_rs2, ex_rd, ex_data1, ex_data2, ex_imm  out  (matching widths)  registered copies.
- stall_if_id  out  1  combinational; upstream must hold PC and the IF/ID register.
- bubble_cnt  out  CNT_W  count of load-use bubbles inserted.

Behaviour:
- Reset: every ex_* output is 0, ex_valid is 0, flush_pending is 0 and bubble_cnt is 0. stall_if_id is 0 while rst is high. Reset in mid-stall discards all state.
- Bubble: ex_valid=0 and every ex_* field is 0, so no write enable or jump is active.
- load_use = id_valid & ex_valid & ex_rmem & ex_wreg & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)). No register is exempt from the match.
- kill = flush | flush_pending.
- Next-state priority, evaluated per clock edge:
  1. rst: the reset values above.
  2. ex_stall: all ex_* hold. If flush is high, set flush_pending=1.
  3. kill: load a bubble, clear flush_pending, no count.
  4. load_use: load a bubble, increment bubble_cnt.
  5. Otherwise: capture the id_* inputs; ex_valid = id_valid.
- stall_if_id = ~rst & (ex_stall | (load_use & ~kill)).
- A load-use stall lasts exactly one cycle, because the following cycle EX holds a bubble and no longer matches.
- bubble_cnt saturates at all-ones; it never wraps.
- Latency: 1 cycle from id_* to ex_*. Throughput: 1 instruction per cycle when there is no hazard.
- A flush arriving while flush_pending is already set has no additional effect.
- id_valid=0 is captured as a bubble: all fields are zeroed, regardless of the other id_* inputs.

Test Plan:
- Reset: apply rst for 2 cycles with arbitrary id_* inputs -> all ex_* are 0, bubble_cnt=0, stall_if_id=0.
- Pass-through: id_valid=1, alu_ins=3'b010, wreg=1, rd=5, data1=128'hA5..A5 -> next cycle ex_valid=1, ex_alu_ins=010, ex_rd=5, ex_data1 matches; stall_if_id=0.
- Load-use: EX holds a load (rmem=1, wreg=1, rd=3); ID instruction has rs2=3, rs2_used=1 -> stall_if_id=1 for one cycle, EX becomes a bubble, bubble_cnt=1; the next cycle captures the ID instruction.
  - Same case with rs2_used=0 -> no stall.
- Flush during load-use: both conditions in the same cycle -> EX bubble, stall_if_id=0, bubble_cnt unchanged.
- Flush under back-pressure: ex_stall=1 and flush=1 for 1 cycle, then ex_stall=1 for 2 more cycles -> EX holds throughout, stall_if_id=1; on the first cycle with ex_stall=0, EX loads a bubble and flush_pending clears.
- Counter saturation: preload via CNT_W=4 and run 20 load-use events -> bubble_cnt stops at 15.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the vector ASIP.
// Registers the decoded control word and operands for execute, inserts a
// bubble on load-use hazards and branch flushes, holds under execute
// back-pressure and counts the load-use bubbles it inserts (saturating).
module id_ex_stage #(
    parameter int DATA_W = 128,
    parameter int REG_AW = 4,
    parameter int IMM_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_wmem,
    input  logic              id_rmem,
    input  logic              id_wreg,
    input  logic              id_cond_en,
    input  logic              id_jmp_sel,
    input  logic              id_vf,
    input  logic [1:0]        id_jmp_f,
    input  logic [2:0]        id_alu_ins,
    input  logic [1:0]        id_extnd_sel,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [DATA_W-1:0] id_data1,
    input  logic [DATA_W-1:0] id_data2,
    input  logic [IMM_W-1:0]  id_imm,
    input  logic              flush,
    input  logic              ex_stall,
    output logic              ex_valid,
    output logic              ex_wmem,
    output logic              ex_rmem,
    output logic              ex_wreg,
    output logic              ex_cond_en,
    output logic              ex_jmp_sel,
    output logic              ex_vf,
    output logic [1:0]        ex_jmp_f,
    output logic [2:0]        ex_alu_ins,
    output logic [1:0]        ex_extnd_sel,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_data1,
    output logic [DATA_W-1:0] ex_data2,
    output logic [IMM_W-1:0]  ex_imm,
    output logic              stall_if_id,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic flush_pending;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic kill;
    logic take;
    logic zero;

    // Saturating increment: the profiling counter sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (&v) ? v : v + one;
    endfunction

    // A load in EX whose destination feeds a source the ID instruction reads.
    assign rs1_hit  = id_rs1_used & (id_rs1 == ex_rd);
    assign rs2_hit  = id_rs2_used & (id_rs2 == ex_rd);
    assign load_use = id_valid & ex_valid & ex_rmem & ex_wreg & (rs1_hit | rs2_hit);
    assign kill     = flush | flush_pending;

    // A kill outranks the hazard: the killed instruction never needs the load.
    assign stall_if_id = ~rst & (ex_stall | (load_use & ~kill));

    // take: capture a real instruction; zero: load a bubble (or reset).
    assign take = ~ex_stall & ~kill & ~load_use & id_valid;
    assign zero = rst | (~ex_stall & ~take);

    // ID -> EX register: bubble zeroes every field, stall holds everything.
    always_ff @(posedge clk) begin
        if (zero) begin
            ex_valid     <= 1'b0;
            ex_wmem      <= 1'b0;
            ex_rmem      <= 1'b0;
            ex_wreg      <= 1'b0;
            ex_cond_en   <= 1'b0;
            ex_jmp_sel   <= 1'b0;
            ex_vf        <= 1'b0;
            ex_jmp_f     <= '0;
            ex_alu_ins   <= '0;
            ex_extnd_sel <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_data1     <= '0;
            ex_data2     <= '0;
            ex_imm       <= '0;
        end else if (take) begin
            ex_valid     <= 1'b1;
            ex_wmem      <= id_wmem;
            ex_rmem      <= id_rmem;
            ex_wreg      <= id_wreg;
            ex_cond_en   <= id_cond_en;
            ex_jmp_sel   <= id_jmp_sel;
            ex_vf        <= id_vf;
            ex_jmp_f     <= id_jmp_f;
            ex_alu_ins   <= id_alu_ins;
            ex_extnd_sel <= id_extnd_sel;
            ex_rs1       <= id_rs1;
            ex_rs2       <= id_rs2;
            ex_rd        <= id_rd;
            ex_data1     <= id_data1;
            ex_data2     <= id_data2;
            ex_imm       <= id_imm;
        end
    end

    // Remember a flush seen under back-pressure; count load-use bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_pending <= 1'b0;
            bubble_cnt    <= '0;
        end else if (ex_stall) begin
            if (flush) begin
                flush_pending <= 1'b1;
            end
        end else if (kill) begin
            flush_pending <= 1'b0;
        end else if (load_use) begin
            bubble_cnt <= sat_inc(bubble_cnt);
        end
    end

endmodule
